bit_serializer: RTL
===================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: number of bits per word, legal range 2..16.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low (asserted when 0).
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a word to be accepted.
REQ-007 din_ready  output  1  block can accept a word this cycle.
REQ-008 out  output  1  serial bit stream, one bit per clock; feeds the sequence detector's `in`.
REQ-009 out_valid  output  1  `out` carries a data bit this cycle.
REQ-010 word_done  output  1  one-cycle pulse while the last bit of a word is on `out`.

Function
REQ-011 Storage: one holding register (hold, hold_full) plus one shift register (shreg), with a bit counter cnt of width clog2(WIDTH).
REQ-012 A handshake occurs on a rising edge where din_valid=1 and din_ready=1; a word is accepted only on a handshake.
REQ-013 din_ready = NOT hold_full, driven combinationally from registered state only, with no path from din_valid.
REQ-014 The FSM has two states: IDLE (shreg empty) and SHIFT (shreg holds a word being output).
REQ-015 IDLE, handshake, hold empty: din loads directly into shreg, cnt=0, and the FSM goes to SHIFT.
  - The first bit appears on `out` in the cycle after the accepting edge (1-cycle latency).
REQ-016 IDLE with hold_full: this case is unreachable; the FSM shall still load hold into shreg and go to SHIFT.
REQ-017 SHIFT, cnt<WIDTH-1: each edge shifts shreg by one bit toward the output end and increments cnt.
REQ-018 SHIFT, cnt=WIDTH-1 (last bit), hold_full: the edge loads hold into shreg, sets cnt=0, clears hold_full, and the FSM stays in SHIFT.
  - No idle gap between words.
REQ-019 SHIFT, last bit, hold empty, handshake: din loads directly into shreg, cnt=0, and the FSM stays in SHIFT.
  - No gap between words.
REQ-020 SHIFT, last bit, hold empty, no handshake: the FSM goes to IDLE.
REQ-021 SHIFT, not last bit, handshake: din is written to hold and hold_full is set.
REQ-022 Simultaneous events: on the edge where hold moves to shreg, din_ready is 0, so no handshake can collide with the transfer.
REQ-023 out = the current output-end bit of shreg in SHIFT; out = 0 in IDLE.
REQ-024 out_valid = 1 exactly in SHIFT.
REQ-025 word_done = 1 exactly when in SHIFT and cnt=WIDTH-1.
REQ-026 Throughput: with continuous din_valid, the block sustains one bit per clock with out_valid continuously high.
REQ-027 din is never sampled except on a handshake edge; din may change freely at other times.
REQ-028 Outputs are glitch-free functions of registered state; no output combinationally depends on din or din_valid.

Reset
REQ-029 While rst=0, the block shall be in IDLE with hold_full=0, cnt=0, shreg=0, hold=0.
  - Outputs: out=0, out_valid=0, word_done=0, din_ready=1.
REQ-030 Reset asserted mid-word shall abort the word and discard hold within the same cycle (asynchronous); no partial word resumes.
REQ-031 First handshake is possible on the first rising edge after rst returns to 1.

Verification
REQ-032 WIDTH=8, MSB_FIRST=1, one handshake din=8'hB4 from IDLE -> from the next cycle `out` = 1,0,1,1,0,1,0,0 for 8 cycles.
  - out_valid high for those 8 cycles; word_done high on the 8th cycle only; then IDLE with out=0.
REQ-033 din_valid held high with words 8'hA5, 8'h3C, 8'hFF -> 24 consecutive valid bits with no gap.
  - Bit stream A5,3C,FF MSB-first; word_done on cycles 8, 16, 24.
  - din_ready is 0 from the second accept until hold drains.
REQ-034 MSB_FIRST=0, din=8'h01 -> `out` = 1,0,0,0,0,0,0,0.
REQ-035 rst driven to 0 during bit 3 of a word, with hold_full=1 -> same cycle: out_valid=0, out=0, din_ready=1.
  - After release, `out` stays 0 until a new handshake.
REQ-036 din_valid=1 while din_ready=0 with din changing every cycle -> the changing values are never serialized.
  - Only words present on handshake edges appear on `out`, in accept order.
REQ-037 End-to-end: drive bit_serializer output into the sequence detector, with a word containing the detector's target pattern.
  - The detector asserts its match output on the cycle the final pattern bit is on `out`.

Source files
------------

// File: rtl/bit_serializer_if.sv
// Parallel-in / serial-out handshake bundle for bit_serializer.
//   din        : parallel word offered by the producer
//   din_valid  : din holds a word to be accepted
//   din_ready  : serializer can accept a word this cycle
//   out        : serial bit stream, one bit per clock
//   out_valid  : out carries a data bit this cycle
//   word_done  : one-cycle pulse while the last bit of a word is on out
// master = word producer, slave = serializer.
interface bit_serializer_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             out;
   logic             out_valid;
   logic             word_done;

   modport master (
      output din, din_valid,
      input  din_ready, out, out_valid, word_done
   );

   modport slave (
      input  din, din_valid,
      output din_ready, out, out_valid, word_done
   );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register so that
// back-to-back words stream out with no idle cycle between them.
//   clk : rising-edge clock
//   rst : asynchronous reset, active low
//   bus : bit_serializer_if.slave (din/din_valid/din_ready in, out/out_valid/word_done out)
// Parameters: WIDTH (2..16) bits per word, MSB_FIRST selects shift order.
module bit_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic         clk,
   input logic         rst,
   bit_serializer_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             handshake;
   logic             last_bit;
   logic             out_bit;
   logic [WIDTH-1:0] shreg_shifted;

   // Ready depends only on registered state, never on din_valid.
   assign bus.din_ready = ~hold_full_q;
   assign handshake     = bus.din_valid & ~hold_full_q;
   assign last_bit      = (cnt_q == CNT_LAST);

   // Output end of the shift register and the one-step shift toward it.
   generate
      if (MSB_FIRST) begin : g_msb
         assign out_bit       = shreg_q[WIDTH-1];
         assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin : g_lsb
         assign out_bit       = shreg_q[0];
         assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
      end
   endgenerate

   // Outputs decode registered state only.
   assign bus.out       = (state_q == SHIFT) & out_bit;
   assign bus.out_valid = (state_q == SHIFT);
   assign bus.word_done = (state_q == SHIFT) & last_bit;

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         cnt_q       <= cnt_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      cnt_d       = cnt_q;

      case (state_q)
         IDLE: begin
            // hold_full in IDLE cannot occur, but drain it if it ever does.
            if (hold_full_q) begin
               shreg_d     = hold_q;
               hold_full_d = 1'b0;
               cnt_d       = '0;
               state_d     = SHIFT;
            end else if (handshake) begin
               shreg_d = bus.din;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (!last_bit) begin
               shreg_d = shreg_shifted;
               cnt_d   = cnt_q + CNT_W'(1);
               if (handshake) begin
                  hold_d      = bus.din;
                  hold_full_d = 1'b1;
               end
            end else if (hold_full_q) begin
               // din_ready is low here, so no handshake can collide.
               shreg_d     = hold_q;
               hold_full_d = 1'b0;
               cnt_d       = '0;
            end else if (handshake) begin
               shreg_d = bus.din;
               cnt_d   = '0;
            end else begin
               shreg_d = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end
endmodule
